// File: rtl/even_pipe_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : even_pipe_result_stage
// Description : Result staging pipeline behind the even-pipe ALU. Results
//               enter the slot that matches the latency they already spent
//               in the ALU. They shift one slot per cycle, so every result
//               reaches the writeback slot a fixed number of cycles after
//               issue. Two bypass ports forward in-flight results to
//               operand fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module even_pipe_result_stage #(
  parameter int DATA_WIDTH = 128,
  parameter int RT_WIDTH   = 7,
  parameter int PIPE_DEPTH = 7,
  parameter int LAT_WIDTH  = 3
) (
  input  logic                  clk_fake,
  input  logic                  reset,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic [RT_WIDTH-1:0]   res_rt,
  input  logic [LAT_WIDTH-1:0]  res_lat,
  input  logic                  flush,
  input  logic [RT_WIDTH-1:0]   fwd_addr_a,
  input  logic [RT_WIDTH-1:0]   fwd_addr_b,
  output logic                  fwd_hit_a,
  output logic [DATA_WIDTH-1:0] fwd_data_a,
  output logic                  fwd_hit_b,
  output logic [DATA_WIDTH-1:0] fwd_data_b,
  output logic                  wb_en,
  output logic [RT_WIDTH-1:0]   wb_rt,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  collision_err,
  output logic                  lat_err
);

  // Largest legal latency, expressed in the width of res_lat.
  localparam logic [LAT_WIDTH-1:0] c_MAX_LAT = LAT_WIDTH'(PIPE_DEPTH);

  // Staging slots 1..PIPE_DEPTH; slot PIPE_DEPTH is the writeback slot.
  logic                  r_valid [1:PIPE_DEPTH];
  logic [RT_WIDTH-1:0]   r_rt    [1:PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] r_data  [1:PIPE_DEPTH];

  logic                  r_collision_err;
  logic                  r_lat_err;

  // Slot contents after the shift step (flush already applied).
  logic                  w_sh_valid [1:PIPE_DEPTH];
  logic [RT_WIDTH-1:0]   w_sh_rt    [1:PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] w_sh_data  [1:PIPE_DEPTH];

  // Slot contents after the insert step.
  logic                  w_nxt_valid [1:PIPE_DEPTH];
  logic [RT_WIDTH-1:0]   w_nxt_rt    [1:PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] w_nxt_data  [1:PIPE_DEPTH];

  logic                  w_lat_legal;
  logic                  w_insert_req;
  logic                  w_lat_bad;
  logic                  w_collision;

  // Shift network. Slot 1 always empties. The middle slots take their
  // predecessor. The writeback slot keeps its rt/data when nothing valid
  // arrives, so wb_rt/wb_data hold their last written-back values. Flush
  // kills everything that would otherwise move forward.
  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_shift
    if (k == 1) begin : g_head
      assign w_sh_valid[k] = 1'b0;
      assign w_sh_rt[k]    = r_rt[k];
      assign w_sh_data[k]  = r_data[k];
    end else if (k == PIPE_DEPTH) begin : g_wb
      assign w_sh_valid[k] = r_valid[k-1] & ~flush;
      assign w_sh_rt[k]    = w_sh_valid[k] ? r_rt[k-1]   : r_rt[k];
      assign w_sh_data[k]  = w_sh_valid[k] ? r_data[k-1] : r_data[k];
    end else begin : g_mid
      assign w_sh_valid[k] = r_valid[k-1] & ~flush;
      assign w_sh_rt[k]    = r_rt[k-1];
      assign w_sh_data[k]  = r_data[k-1];
    end
  end

  // Classify the incoming result. Flush discards it silently, so it also
  // masks both error conditions.
  always_comb begin
    w_lat_legal  = (res_lat != '0) && (res_lat <= c_MAX_LAT);
    w_insert_req = res_valid & ~flush & w_lat_legal;
    w_lat_bad    = res_valid & ~flush & ~w_lat_legal;
  end

  // Insert the new result into slot res_lat. An older entry already shifted
  // into that slot has priority, and the new result is dropped.
  always_comb begin
    w_collision = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      w_nxt_valid[k] = w_sh_valid[k];
      w_nxt_rt[k]    = w_sh_rt[k];
      w_nxt_data[k]  = w_sh_data[k];
      if (w_insert_req && (res_lat == LAT_WIDTH'(k))) begin
        if (w_sh_valid[k]) begin
          w_collision = 1'b1;
        end else begin
          w_nxt_valid[k] = 1'b1;
          w_nxt_rt[k]    = res_rt;
          w_nxt_data[k]  = res_data;
        end
      end
    end
  end

  // Slot registers and error pulses. Reset empties the pipe and zeroes the
  // writeback slot.
  always_ff @(posedge clk_fake) begin
    if (reset) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_rt[k]    <= '0;
        r_data[k]  <= '0;
      end
      r_collision_err <= 1'b0;
      r_lat_err       <= 1'b0;
    end else begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        r_valid[k] <= w_nxt_valid[k];
        r_rt[k]    <= w_nxt_rt[k];
        r_data[k]  <= w_nxt_data[k];
      end
      r_collision_err <= w_collision;
      r_lat_err       <= w_lat_bad;
    end
  end

  // Bypass port A: scan from the writeback slot down, so the lowest matching
  // slot (the youngest result) wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (r_valid[k] && (r_rt[k] == fwd_addr_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = r_data[k];
      end
    end
  end

  // Bypass port B: same lookup, independent of port A.
  always_comb begin
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (r_valid[k] && (r_rt[k] == fwd_addr_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = r_data[k];
      end
    end
  end

  assign wb_en         = r_valid[PIPE_DEPTH];
  assign wb_rt         = r_rt[PIPE_DEPTH];
  assign wb_data       = r_data[PIPE_DEPTH];
  assign collision_err = r_collision_err;
  assign lat_err       = r_lat_err;

endmodule
`default_nettype wire

// File: doc/even_pipe_result_stage.md
Name: even_pipe_result_stage

Overview:
- Sits directly downstream of the even-pipe ALU. Captures each ALU result together with its destination register and the latency it already spent in the ALU.
- Inserts the result into a fixed-depth staging pipeline so that every result, whatever its latency, reaches register-file writeback exactly PIPE_DEPTH cycles after issue.
- Provides two bypass lookup ports so operand fetch can forward in-flight results before they are written back.

Parameters:
DATA_WIDTH, 128, width of result data (quadword)
RT_WIDTH, 7, destination register address width (128 registers)
PIPE_DEPTH, 7, number of staging slots; slot PIPE_DEPTH is the writeback slot
LAT_WIDTH, 3, width of res_lat

Ports:
clk_fake  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
res_valid  input  1  ALU result present this cycle
res_data  input  DATA_WIDTH  ALU result
res_rt  input  RT_WIDTH  destination register of result
res_lat  input  LAT_WIDTH  cycles already elapsed since issue; legal 1..PIPE_DEPTH
flush  input  1  discard all in-flight results not yet in writeback slot
fwd_addr_a  input  RT_WIDTH  bypass lookup address A
fwd_addr_b  input  RT_WIDTH  bypass lookup address B
fwd_hit_a  output  1  a staged valid entry matches fwd_addr_a
fwd_data_a  output  DATA_WIDTH  data of matching entry for A, 0 when no hit
fwd_hit_b  output  1  as fwd_hit_a for B
fwd_data_b  output  DATA_WIDTH  as fwd_data_a for B
wb_en  output  1  register-file write enable
wb_rt  output  RT_WIDTH  register-file write address
wb_data  output  DATA_WIDTH  register-file write data
collision_err  output  1  one-cycle pulse: insertion collided with a shifting entry
lat_err  output  1  one-cycle pulse: res_valid with illegal res_lat

Behaviour:
- Storage: slots 1..PIPE_DEPTH, each holding {valid, rt, data}. Slot PIPE_DEPTH drives wb_en/wb_rt/wb_data directly, so the writeback outputs are registered.
- Reset (sync): all valid bits = 0; wb_en=0, wb_rt=0, wb_data=0; collision_err=0, lat_err=0. A reset asserted mid-flight drops every entry, and no writeback occurs on the following cycle.
- Each rising edge, in this order:
  (1) shift: slot k+1 <= slot k for k=1..PIPE_DEPTH-1; slot 1 <= invalid. The old content of slot PIPE_DEPTH is retired (written back).
  (2) insert: if res_valid and 1<=res_lat<=PIPE_DEPTH, slot res_lat <= {1, res_rt, res_data}.
- Timing: a result inserted at edge t with res_lat=L shows wb_en=1 after edge t+(PIPE_DEPTH-L). res_lat=PIPE_DEPTH gives wb_en=1 directly after the insert edge.
- Collision: if step (1) moves a valid entry into slot res_lat in the same edge as an insert, the shifted (older) entry is kept and the new result is dropped. collision_err=1 for one cycle, after that edge.
- Illegal latency: res_lat=0 or res_lat>PIPE_DEPTH with res_valid=1. The result is dropped and lat_err=1 for one cycle. Both error flags are registered and are 0 in any cycle without the triggering event.
- flush: at the edge, slots 1..PIPE_DEPTH-1 become invalid after the shift, so nothing shifts into the writeback slot. The entry already in slot PIPE_DEPTH completes writeback. An insert in the same cycle as flush is discarded (flush wins) and raises no error flags.
- Bypass (combinational from registered slots only; the same-cycle res_* input is not forwarded):
  - hit = any valid slot with rt == fwd_addr.
  - When several slots match, the lowest slot index wins.
  - Slot PIPE_DEPTH participates in the lookup.
  - fwd_data = 0 when there is no hit.
  - Ports A and B are independent; identical addresses give identical results.
- wb_en=0 holds wb_rt/wb_data at their last values. Consumers must qualify them with wb_en.
- No backpressure: the block accepts one result every cycle.

Test Plan:
- Reset then idle 10 cycles -> wb_en, fwd_hit_a/b, collision_err, lat_err all 0; wb_data=0.
- res_valid, rt=5, data=0x11..11, lat=1 at edge 0 -> wb_en=1, wb_rt=5 after edge 6 only. fwd_addr_a=5 hits, returning 0x11..11, from after edge 0 through the writeback cycle.
- Edge 0: rt=3, lat=2 (mul); edge 1: rt=4, lat=1 -> rt=3 writes back after edge 5, rt=4 after edge 7, no errors. Edge 0: rt=3, lat=1; edge 1: rt=4, lat=2 -> collision_err=1 after edge 1, rt=4 dropped, rt=3 writes back after edge 6.
- Two entries with rt=9, in slot 2 (data A) and slot 5 (data B), fwd_addr_a=fwd_addr_b=9 -> both ports return data A.
- Entries in slots 3 and 7 plus an insert with lat=1, all with flush=1 -> only the slot-7 entry writes back the next cycle; no writeback afterward; no error flags.
- res_valid with lat=0, then lat=7 (legal) -> lat_err pulses once, only after the first edge. The lat=7 result gives wb_en=1 directly after its insert edge.
